// File: rtl/launch_pkg.sv
// Shared types and default parameter values for the processor launch controller.
package launch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RST,
    PULSE,
    RUN,
    DONE
  } launch_state_t;

  localparam int DEF_RST_CYCLES     = 2;
  localparam int DEF_START_CYCLES   = 1;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/launch_ctrl_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/launch_ctrl.sv
// Launch sequencer: holds the core in reset, pulses Start, then counts RUN cycles until Ack.
// Optional RUN timeout is compiled in with `define LAUNCH_TIMEOUT_EN.
module launch_ctrl
  import launch_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Ack,
  output logic             CoreReset,
  output logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);

  launch_state_t state;
  logic [7:0]    phase;
  logic          accept;
  logic          at_limit;
  logic          cnt_clear;
  logic          cnt_en;

  assign accept = ((state == IDLE) || (state == DONE)) && Go;

`ifdef LAUNCH_TIMEOUT_EN
  assign at_limit = (CycleCount == CNT_W'(TIMEOUT_CYCLES));
`else
  assign at_limit = 1'b0;
`endif

  // Clearing on reset and on accept keeps CycleCount coherent with the FSM registers.
  assign cnt_clear = !Reset || accept;
  assign cnt_en    = (state == RUN) && !Ack && !at_limit;

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk   (Clk),
    .clear (cnt_clear),
    .enable(cnt_en),
    .count (CycleCount)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      phase     <= '0;
      CoreReset <= 1'b1;
      Start     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          CoreReset <= 1'b0;
          if (Go) begin
            state     <= HOLD_RST;
            phase     <= '0;
            CoreReset <= 1'b1;
            Busy      <= 1'b1;
            Done      <= 1'b0;
          end
        end
        HOLD_RST: begin
          if (phase == RST_LAST) begin
            state     <= PULSE;
            phase     <= '0;
            CoreReset <= 1'b0;
            Start     <= 1'b1;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        PULSE: begin
          if (phase == START_LAST) begin
            state <= RUN;
            phase <= '0;
            Start <= 1'b0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        RUN: begin
          if (Ack || at_limit) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          phase     <= '0;
          CoreReset <= 1'b0;
          Start     <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAUNCH_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (!Reset || accept) begin
      TimedOut <= 1'b0;
    end else if ((state == RUN) && !Ack && at_limit) begin
      TimedOut <= 1'b1;
    end
  end
`else
  assign TimedOut = 1'b0;
`endif

endmodule

// File: tb/tb_launch_ctrl.sv
// Randomized scoreboard bench for launch_ctrl; expected launch shape comes from a cycle-budget model.
module tb_launch_ctrl;

  localparam int RST   = 2;
  localparam int START = 1;
  localparam int CW    = 16;
  localparam int TO    = 20;

  logic          Clk = 1'b0;
  logic          Reset, Go, Ack;
  logic          CoreReset, Start, Busy, Done, TimedOut;
  logic [CW-1:0] CycleCount;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int crst;
    int start;
    int busy;
    int count;
    int to;
  } exp_t;

  exp_t exp_q[$];

  launch_ctrl #(
    .RST_CYCLES    (RST),
    .START_CYCLES  (START),
    .CNT_W         (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Go        (Go),
    .Ack       (Ack),
    .CoreReset (CoreReset),
    .Start     (Start),
    .Busy      (Busy),
    .Done      (Done),
    .TimedOut  (TimedOut),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // A launch lasts RST + START cycles of preamble, then one RUN cycle per Ack-low
  // cycle (capped by the timeout when compiled in), plus the RUN cycle that ends it.
  function automatic exp_t model(input int n);
    exp_t e;
    int   run;
    run  = n;
    e.to = 0;
`ifdef LAUNCH_TIMEOUT_EN
    if (n > TO) begin
      run  = TO;
      e.to = 1;
    end
`endif
    e.crst  = RST;
    e.start = START;
    e.count = run;
    e.busy  = RST + START + run + 1;
    return e;
  endfunction

  // n: RUN cycles before Ack rises; early: Ack high during preamble;
  // noise: 0 none, 1 random Go, 2 Go on cycles 2 and 5.
  task automatic launch(input int n, input bit early, input int noise);
    exp_t e;
    int   run_first;
    e         = model(n);
    run_first = RST + START + 1;
    @(negedge Clk);
    Reset = 1'b1;
    Go    = 1'b1;
    Ack   = early;
    @(posedge Clk);
    exp_q.push_back(e);
    for (int j = 1; j <= e.busy; j++) begin
      @(negedge Clk);
      case (noise)
        1:       Go = ($urandom % 3) == 0;
        2:       Go = (j == 2) || (j == 5);
        default: Go = 1'b0;
      endcase
      Ack = (early && (j < run_first)) || (j >= run_first + n);
      @(posedge Clk);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge Clk);
      Go  = 1'b0;
      Ack = $urandom % 2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_corereset"}, int'(CoreReset), 1);
    chk({tag, "_flags"}, int'({Start, Busy, Done, TimedOut}), 0);
    chk({tag, "_count"}, int'(CycleCount), 0);
  endtask

  // Scoreboard monitor: measures each launch as the DUT plays it out, compares when Done rises.
  initial begin : monitor
    int crst_n, start_n, busy_n;
    bit done_prev;
    exp_t e;
    crst_n = 0; start_n = 0; busy_n = 0; done_prev = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset) begin
        crst_n = 0; start_n = 0; busy_n = 0; done_prev = 1'b0;
      end else begin
        if (Busy) begin
          busy_n++;
          if (CoreReset) crst_n++;
          if (Start) start_n++;
        end
        if (Done && !done_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("corereset_cycles", crst_n, e.crst);
            chk("start_cycles", start_n, e.start);
            chk("busy_cycles", busy_n, e.busy);
            chk("cyclecount", int'(CycleCount), e.count);
            chk("timedout", int'(TimedOut), e.to);
            chk("busy_at_done", int'(Busy), 0);
          end
          crst_n = 0; start_n = 0; busy_n = 0;
        end
        done_prev = Done;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int busy_cnt;
    Reset = 1'b0;
    Go    = 1'b0;
    Ack   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check_reset_outputs("por");
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("release_corereset", int'(CoreReset), 0);
    chk("release_busy", int'(Busy), 0);

    idle(2);
    launch(7, 1'b0, 0);
    idle(2);
    launch(0, 1'b1, 0);
    idle(1);
    launch(7, 1'b0, 2);
    launch(3, 1'b0, 0);
    launch(0, 1'b0, 1);
    idle(3);

`ifdef LAUNCH_TIMEOUT_EN
    launch(40, 1'b0, 1);
    idle(2);
    launch(TO, 1'b0, 0);
    idle(2);
`else
    @(negedge Clk);
    Go  = 1'b1;
    Ack = 1'b0;
    @(posedge Clk);
    busy_cnt = 0;
    for (int j = 1; j <= 100 + RST + START; j++) begin
      @(negedge Clk);
      Go  = $urandom % 2;
      Ack = 1'b0;
      @(posedge Clk);
      #1;
      if (Busy) busy_cnt++;
    end
    chk("no_timeout_busy", busy_cnt, 100 + RST + START);
    @(negedge Clk);
    Reset = 1'b0;
    Go    = 1'b0;
    @(posedge Clk);
    #1;
    check_reset_outputs("abort");
`endif

    // Reset in RUN once five Ack-low cycles have been counted.
    @(negedge Clk);
    Reset = 1'b1;
    Go    = 1'b1;
    Ack   = 1'b0;
    @(posedge Clk);
    for (int j = 1; j <= RST + START + 5; j++) begin
      @(negedge Clk);
      Go  = 1'b0;
      Ack = 1'b0;
      @(posedge Clk);
    end
    #1;
    chk("midrun_count", int'(CycleCount), 5);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_reset_outputs("midrun_reset");
    launch(4, 1'b0, 0);
    idle(1);

    for (int k = 0; k < 25; k++) begin
      launch($urandom_range(0, 24), 1'($urandom % 2), int'($urandom_range(0, 2)));
      idle($urandom_range(0, 3));
    end

    idle(3);
    @(posedge Clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
